// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, widths and controller state encoding.
package fb_pkg;

    localparam int unsigned FB_WIDTH      = 160;
    localparam int unsigned FB_HEIGHT     = 120;
    localparam int unsigned FB_WORDS      = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned FB_COLOR_BITS = 9;
    localparam int unsigned FB_ADDRW      = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_e;

endpackage

// File: rtl/fb_clear_seq.sv
// Clear sequencer: walks the framebuffer address range with a latched fill colour,
// flags the final address and pulses clear_done the cycle after it is written.
import fb_pkg::*;

module fb_clear_seq (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     active,
    input  logic [FB_COLOR_BITS-1:0] color_in,
    output logic [FB_ADDRW-1:0]      addr,
    output logic [FB_COLOR_BITS-1:0] color,
    output logic                     last,
    output logic                     clear_done
);

    logic [FB_ADDRW-1:0]      addr_q;
    logic [FB_COLOR_BITS-1:0] color_q;
    logic                     done_q;

    // Terminal address reached while the clear is running.
    always_comb begin
        last = active && (addr_q == FB_ADDRW'(FB_WORDS - 1));
    end

    // Address counter, colour latch and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            color_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= last;
            if (start) begin
                addr_q  <= '0;
                color_q <= color_in;
            end else if (active) begin
                addr_q <= addr_q + FB_ADDRW'(1);
            end
        end
    end

    assign addr       = addr_q;
    assign color      = color_q;
    assign clear_done = done_q;

endmodule

// File: rtl/fb_writer.sv
// Framebuffer writer: clips renderer draw beats, converts them to linear addresses
// through a 2-stage pipeline and drives the RAM write port; also hosts the clear
// sequencer. Define FB_WRITER_STATS_EN to implement the clip/drop counters.
import fb_pkg::*;

module fb_writer (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              Draw_X,
    input  logic [31:0]              Draw_Y,
    input  logic [31:0]              Draw_Color,
    input  logic                     Enable_Draw,
    input  logic                     clear_req,
    input  logic [FB_COLOR_BITS-1:0] clear_color,
    output logic                     fb_we,
    output logic [FB_ADDRW-1:0]      fb_addr,
    output logic [FB_COLOR_BITS-1:0] fb_data,
    output logic                     busy,
    output logic                     clear_done,
    output logic [15:0]              clip_count,
    output logic [15:0]              drop_count
);

    fb_state_e state_q, state_d;

    logic                     in_range;
    logic                     accept;
    logic                     start;
    logic                     seq_last;
    logic [FB_ADDRW-1:0]      seq_addr;
    logic [FB_COLOR_BITS-1:0] seq_color;

    logic                     s1_valid_q;
    logic [7:0]               s1_x_q;
    logic [6:0]               s1_y_q;
    logic [FB_COLOR_BITS-1:0] s1_color_q;
    logic [16:0]              lin_addr;

    logic                     draw_we_q;
    logic [FB_ADDRW-1:0]      draw_addr_q;
    logic [FB_COLOR_BITS-1:0] draw_data_q;

    logic unused_color_bits;
    assign unused_color_bits = ^Draw_Color[31:FB_COLOR_BITS];

    // Beat qualification; full 32-bit compares so negative coordinates clip.
    always_comb begin
        in_range = (Draw_X < 32'(FB_WIDTH)) && (Draw_Y < 32'(FB_HEIGHT));
        accept   = (state_q == IDLE) && !clear_req;
        start    = (state_q == IDLE) && clear_req;
    end

    // Next-state logic: clear_req is only honoured from IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (clear_req) state_d = CLEAR;
            CLEAR:   if (seq_last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Stage 1: register the beat; invalidated when a clear starts or runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_color_q <= '0;
        end else begin
            s1_valid_q <= accept && Enable_Draw && in_range;
            s1_x_q     <= Draw_X[7:0];
            s1_y_q     <= Draw_Y[6:0];
            s1_color_q <= Draw_Color[FB_COLOR_BITS-1:0];
        end
    end

    // Linear address y*160+x as (y<<7)+(y<<5)+x.
    always_comb begin
        lin_addr = ({10'd0, s1_y_q} << 7) + ({10'd0, s1_y_q} << 5) + {9'd0, s1_x_q};
    end

    // Stage 2: write-port registers; a starting clear flushes the in-flight beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            draw_we_q   <= 1'b0;
            draw_addr_q <= '0;
            draw_data_q <= '0;
        end else begin
            draw_we_q   <= s1_valid_q && accept;
            draw_addr_q <= lin_addr[FB_ADDRW-1:0];
            draw_data_q <= s1_color_q;
        end
    end

    fb_clear_seq u_clear_seq (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .active     (state_q == CLEAR),
        .color_in   (clear_color),
        .addr       (seq_addr),
        .color      (seq_color),
        .last       (seq_last),
        .clear_done (clear_done)
    );

    // Write-port mux: the clear path owns the port for the whole clear.
    always_comb begin
        busy = (state_q == CLEAR);
        if (busy) begin
            fb_we   = 1'b1;
            fb_addr = seq_addr;
            fb_data = seq_color;
        end else begin
            fb_we   = draw_we_q;
            fb_addr = draw_addr_q;
            fb_data = draw_data_q;
        end
    end

`ifdef FB_WRITER_STATS_EN
    logic        clip_hit, drop_hit;
    logic [15:0] clip_q, drop_q;

    // Classify each enabled beat as clipped or dropped.
    always_comb begin
        clip_hit = Enable_Draw && accept && !in_range;
        drop_hit = Enable_Draw && !accept;
    end

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            clip_q <= '0;
            drop_q <= '0;
        end else begin
            if (clip_hit && (clip_q != 16'hFFFF)) clip_q <= clip_q + 16'd1;
            if (drop_hit && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
        end
    end

    assign clip_count = clip_q;
    assign drop_count = drop_q;
`else
    assign clip_count = '0;
    assign drop_count = '0;
`endif

endmodule
